// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clk_div_bank multi-channel clock divider.
package clk_div_pkg;

  localparam int NUM_CH_DEF       = 4;
  localparam int CNT_W_DEF        = 32;
  localparam int DEFAULT_DIV_DEF  = 2;
  localparam int DEFAULT_HIGH_DEF = 1;

  // Channel-select width; a single channel still needs one select bit.
  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_bank_if.sv
// Register-style write port used to reprogram the divider channels.
interface clk_div_bank_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  localparam int CH_W = ch_w(NUM_CH);

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic [CNT_W-1:0] wr_high;

  modport master (output wr_en, output wr_ch, output wr_div, output wr_high);
  modport slave  (input  wr_en, input  wr_ch, input  wr_div, input  wr_high);

endinterface

// File: rtl/clk_div_chan.sv
// One divider channel: shadow and active period/high-time, counter, registered outputs.
// The sync input exists only when CLKDIV_SYNC_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_DIV  = DEFAULT_DIV_DEF,
  parameter int DEFAULT_HIGH = DEFAULT_HIGH_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  input  logic [CNT_W-1:0] wr_high,
`ifdef CLKDIV_SYNC_EN
  input  logic             sync,
`endif
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_HIGH);
  localparam logic [CNT_W-1:0] RST_CNT  = (DEFAULT_DIV == 0) ? '0 : CNT_W'(DEFAULT_DIV - 1);

  logic [CNT_W-1:0] sdiv_q, sdiv_d, shigh_q, shigh_d;
  logic [CNT_W-1:0] adiv_q, adiv_d, ahigh_q, ahigh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d, tick_q, tick_d;
  logic             boundary;

  // A stopped channel re-examines its shadow every edge, so a restart is a wrap.
  always_comb begin
    boundary = (adiv_q == '0) || (cnt_q == adiv_q - CNT_W'(1));
`ifdef CLKDIV_SYNC_EN
    boundary = boundary || sync;
`endif
    adiv_d  = adiv_q;
    ahigh_d = ahigh_q;
    cnt_d   = cnt_q + CNT_W'(1);
    tick_d  = 1'b0;
    if (boundary) begin
      adiv_d  = sdiv_q;
      ahigh_d = shigh_q;
      cnt_d   = '0;
      tick_d  = (sdiv_q != '0);
    end
    sdiv_d    = wr_en ? wr_div  : sdiv_q;
    shigh_d   = wr_en ? wr_high : shigh_q;
    clk_out_d = (adiv_d != '0) && (cnt_d < ahigh_d);
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      sdiv_q    <= RST_DIV;
      shigh_q   <= RST_HIGH;
      adiv_q    <= RST_DIV;
      ahigh_q   <= RST_HIGH;
      cnt_q     <= RST_CNT;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      sdiv_q    <= sdiv_d;
      shigh_q   <= shigh_d;
      adiv_q    <= adiv_d;
      ahigh_q   <= ahigh_d;
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable clock dividers sharing one write port.
// Define CLKDIV_SYNC_EN to add the sync input that phase-aligns all channels.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = NUM_CH_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int DEFAULT_DIV  = DEFAULT_DIV_DEF,
  parameter int DEFAULT_HIGH = DEFAULT_HIGH_DEF
) (
  input  logic              CLK,
  input  logic              RST_N,
  clk_div_bank_if.slave     wr,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync,
`endif
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  logic [NUM_CH-1:0] ch_wr_en;

  // Out-of-range channel numbers match no index and are dropped here.
  always_comb begin
    ch_wr_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wr_en[i] = wr.wr_en && (32'(wr.wr_ch) == i);
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    clk_div_chan #(
      .CNT_W        (CNT_W),
      .DEFAULT_DIV  (DEFAULT_DIV),
      .DEFAULT_HIGH (DEFAULT_HIGH)
    ) u_chan (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .wr_en   (ch_wr_en[g]),
      .wr_div  (wr.wr_div),
      .wr_high (wr.wr_high),
`ifdef CLKDIV_SYNC_EN
      .sync    (sync),
`endif
      .clk_out (clk_out[g]),
      .tick    (tick[g])
    );
  end

endmodule
